// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_pkg
// Description : Shared types and default constants for the PC generator:
//               sequencer state encoding and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_gen_pkg;

  localparam int DEFAULT_XLEN        = 32;
  localparam int DEFAULT_INSTR_BYTES = 4;
  localparam int DEFAULT_RAS_DEPTH   = 4;

  // Fetch sequencer states. IDLE is the reset state and never re-entered
  // except through reset.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_if
// Description : Control/request bundle between the pipeline and the PC
//               generator. The master side issues requests and observes the
//               fetch PC; the slave side is the PC generator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_gen_if #(
  parameter int XLEN = pc_gen_pkg::DEFAULT_XLEN
) ();

  logic            start_i;
  logic            halt_i;
  logic            resume_i;
  logic            stall_i;
  logic            trap_i;
  logic [XLEN-1:0] trap_vec_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            jump_i;
  logic [XLEN-1:0] jump_pc_i;
  logic            call_i;
  logic            ret_i;
  logic [XLEN-1:0] ret_pc_i;
  logic [XLEN-1:0] pc_o;
  logic            valid_o;
  logic            ras_hit_o;

  // Pipeline side: drives requests, consumes the fetch address.
  modport master (
    output start_i, halt_i, resume_i, stall_i,
    output trap_i, trap_vec_i,
    output redirect_i, redirect_pc_i,
    output jump_i, jump_pc_i, call_i,
    output ret_i, ret_pc_i,
    input  pc_o, valid_o, ras_hit_o
  );

  // PC generator side.
  modport slave (
    input  start_i, halt_i, resume_i, stall_i,
    input  trap_i, trap_vec_i,
    input  redirect_i, redirect_pc_i,
    input  jump_i, jump_pc_i, call_i,
    input  ret_i, ret_pc_i,
    output pc_o, valid_o, ras_hit_o
  );

endinterface
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack. ptr_q addresses the next free
//               slot, so the top of stack is ptr_q-1. When full, a push lands
//               on the oldest entry and the count stays saturated. A
//               simultaneous push and pop rewrites the top in place.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int XLEN      = DEFAULT_XLEN,
  parameter int RAS_DEPTH = DEFAULT_RAS_DEPTH
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int               PTR_W   = $clog2(RAS_DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_idx;
  logic             wr_en;
  logic             do_pop;
  logic             do_swap;

  assign top_idx = ptr_q - PTR_W'(1);
  assign top_o   = mem_q[top_idx];
  assign empty_o = (cnt_q == '0);

  // A pop of an empty stack is meaningless; ignore it here as well.
  assign do_pop  = pop_i && !empty_o;
  assign do_swap = push_i && do_pop;

  // Next pointer/count and the entry write for this cycle's operation.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (clear_i) begin
      // Entries become unreachable; the pointer position is irrelevant.
      cnt_d = '0;
    end else if (do_swap) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_i) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
      ptr_d  = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (do_pop) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Fetch PC generator. IDLE/RUN/HALT sequencer with a fixed
//               target priority (trap > redirect > jump > return >
//               sequential), stall handling and a return-address stack for
//               call/return prediction.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSTR_BYTES  = DEFAULT_INSTR_BYTES,
  parameter int              RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
  input  logic    clk_i,
  input  logic    rst_i,
  pc_gen_if.slave bus
);

  localparam logic [XLEN-1:0] PC_INC     = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

  state_e          state_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q;

  logic            in_run;
  logic            trap_ld;
  logic            redirect_ld;
  logic            accept;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_empty;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] pc_seq;

  assign in_run = (state_q == RUN);

  // Traps are honoured in RUN and HALT (they also wake a halted core), never
  // in IDLE. Redirects only matter while fetching. Both ignore stall.
  assign trap_ld     = bus.trap_i && (state_q != IDLE);
  assign redirect_ld = in_run && !bus.trap_i && bus.redirect_i;

  // ID-stage requests (jump/call/ret) and the sequential step only take
  // effect when nothing above them claims the cycle. A halt request freezes
  // the PC for the cycle it is taken, so it blocks them like a stall.
  assign accept = in_run && !bus.trap_i && !bus.redirect_i &&
                  !bus.stall_i && !bus.halt_i;

  assign pc_seq   = pc_q + PC_INC;
  assign ras_push = accept && bus.jump_i && bus.call_i;
  assign ras_pop  = accept && bus.ret_i && !ras_empty;

  // Next fetch address by fixed priority. A call issued together with a
  // return swaps the stack top, and the old top is the target.
  always_comb begin
    pc_d = pc_q;
    if (trap_ld) begin
      pc_d = bus.trap_vec_i & ALIGN_MASK;
    end else if (redirect_ld) begin
      pc_d = bus.redirect_pc_i & ALIGN_MASK;
    end else if (accept) begin
      if (ras_push && ras_pop) begin
        pc_d = ras_top & ALIGN_MASK;
      end else if (bus.jump_i) begin
        pc_d = bus.jump_pc_i & ALIGN_MASK;
      end else if (bus.ret_i) begin
        pc_d = (ras_empty ? bus.ret_pc_i : ras_top) & ALIGN_MASK;
      end else begin
        pc_d = pc_seq;
      end
    end
  end

  // Sequencer, PC register and registered valid flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            state_q <= RUN;
            valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.halt_i && !bus.trap_i) begin
            state_q <= HALT;
            valid_q <= 1'b0;
          end
        end
        HALT: begin
          if (bus.resume_i || bus.trap_i) begin
            state_q <= RUN;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .clear_i     (trap_ld),
    .push_data_i (pc_seq),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );

  assign bus.pc_o      = pc_q;
  assign bus.valid_o   = valid_q;
  assign bus.ras_hit_o = ras_pop;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen
// Description : Self-checking bench for pc_gen: directed vector table,
//               randomized traffic against a queue-based reference model,
//               asynchronous reset and 16-bit wrap sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

  localparam int DEPTH  = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  typedef struct {
    logic        start, halt, resume, stall, trap;
    logic [31:0] trap_vec;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        jump;
    logic [31:0] jump_pc;
    logic        call, ret;
    logic [31:0] ret_pc;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_hit;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  pc_gen_if #(.XLEN(32)) bus ();
  pc_gen_if #(.XLEN(16)) bus16 ();

  pc_gen #(
    .XLEN(32), .RESET_VECTOR(32'h0), .INSTR_BYTES(4), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  pc_gen #(
    .XLEN(16), .RESET_VECTOR(16'h0), .INSTR_BYTES(4), .RAS_DEPTH(DEPTH)
  ) dut16 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus16)
  );

  int n_checks;
  int n_errors;

  // Reference model: mode, PC and a bounded list of return addresses,
  // most recent first.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_hit;
  logic [31:0] n_pc;
  int          n_mode;
  bit          n_clear, n_push, n_pop;
  logic [31:0] n_push_val;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t r(input logic [31:0] pc, input logic vld, input logic hit);
    vec_t t;
    t = '{default: '0};
    t.exp_pc    = pc;
    t.exp_valid = vld;
    t.exp_hit   = hit;
    return t;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic drive(input vec_t v);
    bus.start_i       = v.start;
    bus.halt_i        = v.halt;
    bus.resume_i      = v.resume;
    bus.stall_i       = v.stall;
    bus.trap_i        = v.trap;
    bus.trap_vec_i    = v.trap_vec;
    bus.redirect_i    = v.redirect;
    bus.redirect_pc_i = v.redirect_pc;
    bus.jump_i        = v.jump;
    bus.jump_pc_i     = v.jump_pc;
    bus.call_i        = v.call;
    bus.ret_i         = v.ret;
    bus.ret_pc_i      = v.ret_pc;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pc   = 32'h0;
    m_ras.delete();
  endtask

  task automatic model_eval();
    bit          run, trap_ld, redir, acc, have;
    logic [31:0] top;
    run     = (m_mode == M_RUN);
    trap_ld = bus.trap_i && (m_mode != M_IDLE);
    redir   = run && !bus.trap_i && bus.redirect_i;
    acc     = run && !bus.trap_i && !bus.redirect_i && !bus.stall_i && !bus.halt_i;
    have    = (m_ras.size() > 0);
    top     = have ? m_ras[0] : 32'h0;
    n_clear    = trap_ld;
    n_push     = acc && bus.jump_i && bus.call_i;
    n_pop      = acc && bus.ret_i && have;
    n_push_val = m_pc + 32'd4;
    m_hit      = n_pop;
    n_pc       = m_pc;
    if (trap_ld)    n_pc = align(bus.trap_vec_i);
    else if (redir) n_pc = align(bus.redirect_pc_i);
    else if (acc) begin
      if (n_push && n_pop) n_pc = align(top);
      else if (bus.jump_i) n_pc = align(bus.jump_pc_i);
      else if (bus.ret_i)  n_pc = have ? align(top) : align(bus.ret_pc_i);
      else                 n_pc = m_pc + 32'd4;
    end
    n_mode = m_mode;
    case (m_mode)
      M_IDLE:  if (bus.start_i) n_mode = M_RUN;
      M_RUN:   if (bus.halt_i && !bus.trap_i) n_mode = M_HALT;
      default: if (bus.resume_i || bus.trap_i) n_mode = M_RUN;
    endcase
  endtask

  task automatic model_commit();
    if (n_clear) m_ras.delete();
    else if (n_push && n_pop) m_ras[0] = n_push_val;
    else if (n_push) begin
      m_ras.push_front(n_push_val);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_back());
    end else if (n_pop) void'(m_ras.pop_front());
    m_pc   = n_pc;
    m_mode = n_mode;
  endtask

  // One cycle checked against hand-derived table constants.
  task automatic step_table(input vec_t v, input int idx);
    drive(v);
    @(negedge clk_i);
    model_eval();
    chk($sformatf("tbl%0d pc", idx), bus.pc_o, v.exp_pc);
    chk($sformatf("tbl%0d valid", idx), 32'(bus.valid_o), 32'(v.exp_valid));
    chk($sformatf("tbl%0d ras_hit", idx), 32'(bus.ras_hit_o), 32'(v.exp_hit));
    @(posedge clk_i);
    model_commit();
    #1;
  endtask

  // One cycle checked against the reference model.
  task automatic step_model(input vec_t v, input string tag);
    drive(v);
    @(negedge clk_i);
    model_eval();
    chk({tag, " pc"}, bus.pc_o, m_pc);
    chk({tag, " valid"}, 32'(bus.valid_o), (m_mode == M_RUN) ? 32'd1 : 32'd0);
    chk({tag, " ras_hit"}, 32'(bus.ras_hit_o), 32'(m_hit));
    @(posedge clk_i);
    model_commit();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    n_checks = 0;
    n_errors = 0;
    drive(r(32'h0, 1'b0, 1'b0));
    bus16.start_i = 1'b0;  bus16.halt_i = 1'b0;   bus16.resume_i = 1'b0;
    bus16.stall_i = 1'b0;  bus16.trap_i = 1'b0;   bus16.trap_vec_i = '0;
    bus16.redirect_i = 1'b0; bus16.redirect_pc_i = '0;
    bus16.jump_i = 1'b0;   bus16.jump_pc_i = '0;  bus16.call_i = 1'b0;
    bus16.ret_i = 1'b0;    bus16.ret_pc_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Directed table: inputs for the cycle, outputs expected in that cycle.
    v = r(32'h0,   1'b0, 1'b0); v.trap = 1; v.trap_vec = 32'h500;           tbl.push_back(v);
    v = r(32'h0,   1'b0, 1'b0);                                             tbl.push_back(v);
    v = r(32'h0,   1'b0, 1'b0); v.start = 1;                                tbl.push_back(v);
    v = r(32'h0,   1'b1, 1'b0);                                             tbl.push_back(v);
    v = r(32'h4,   1'b1, 1'b0);                                             tbl.push_back(v);
    v = r(32'h8,   1'b1, 1'b0); v.halt = 1;                                 tbl.push_back(v);
    v = r(32'h8,   1'b0, 1'b0);                                             tbl.push_back(v);
    v = r(32'h8,   1'b0, 1'b0); v.resume = 1;                               tbl.push_back(v);
    v = r(32'h8,   1'b1, 1'b0);                                             tbl.push_back(v);
    v = r(32'hC,   1'b1, 1'b0);                                             tbl.push_back(v);
    v = r(32'h10,  1'b1, 1'b0); v.stall = 1; v.redirect = 1; v.redirect_pc = 32'h123; tbl.push_back(v);
    v = r(32'h120, 1'b1, 1'b0); v.stall = 1;                                tbl.push_back(v);
    v = r(32'h120, 1'b1, 1'b0); v.redirect = 1; v.redirect_pc = 32'h0;      tbl.push_back(v);
    v = r(32'h0,   1'b1, 1'b0); v.jump = 1; v.call = 1; v.jump_pc = 32'h10; tbl.push_back(v);
    v = r(32'h10,  1'b1, 1'b0); v.jump = 1; v.call = 1; v.jump_pc = 32'h20; tbl.push_back(v);
    v = r(32'h20,  1'b1, 1'b0); v.jump = 1; v.call = 1; v.jump_pc = 32'h30; tbl.push_back(v);
    v = r(32'h30,  1'b1, 1'b0); v.jump = 1; v.call = 1; v.jump_pc = 32'h40; tbl.push_back(v);
    v = r(32'h40,  1'b1, 1'b0); v.jump = 1; v.call = 1; v.jump_pc = 32'h80; tbl.push_back(v);
    v = r(32'h80,  1'b1, 1'b1); v.ret = 1; v.ret_pc = 32'hF00;              tbl.push_back(v);
    v = r(32'h44,  1'b1, 1'b1); v.ret = 1; v.ret_pc = 32'hF00;              tbl.push_back(v);
    v = r(32'h34,  1'b1, 1'b1); v.ret = 1; v.ret_pc = 32'hF00;              tbl.push_back(v);
    v = r(32'h24,  1'b1, 1'b1); v.ret = 1; v.ret_pc = 32'hF00;              tbl.push_back(v);
    v = r(32'h14,  1'b1, 1'b0); v.ret = 1; v.ret_pc = 32'hF00;              tbl.push_back(v);
    v = r(32'hF00, 1'b1, 1'b0); v.jump = 1; v.call = 1; v.jump_pc = 32'h200; tbl.push_back(v);
    v = r(32'h200, 1'b1, 1'b1); v.jump = 1; v.call = 1; v.ret = 1; v.jump_pc = 32'h300; v.ret_pc = 32'hBAD0; tbl.push_back(v);
    v = r(32'hF04, 1'b1, 1'b1); v.ret = 1; v.ret_pc = 32'hBAD0;             tbl.push_back(v);
    v = r(32'h204, 1'b1, 1'b0); v.ret = 1; v.ret_pc = 32'h1234;             tbl.push_back(v);
    v = r(32'h1234,1'b1, 1'b0); v.jump = 1; v.call = 1; v.jump_pc = 32'h20; tbl.push_back(v);
    v = r(32'h20,  1'b1, 1'b0); v.trap = 1; v.trap_vec = 32'h800; v.redirect = 1; v.redirect_pc = 32'h100;
                                v.jump = 1; v.call = 1; v.jump_pc = 32'h200; tbl.push_back(v);
    v = r(32'h800, 1'b1, 1'b0); v.ret = 1; v.ret_pc = 32'h600;              tbl.push_back(v);
    v = r(32'h600, 1'b1, 1'b0); v.halt = 1; v.trap = 1; v.trap_vec = 32'h700; tbl.push_back(v);
    v = r(32'h700, 1'b1, 1'b0);                                             tbl.push_back(v);
    v = r(32'h704, 1'b1, 1'b0); v.halt = 1;                                 tbl.push_back(v);
    v = r(32'h704, 1'b0, 1'b0); v.trap = 1; v.trap_vec = 32'h903;           tbl.push_back(v);
    v = r(32'h900, 1'b1, 1'b0); v.stall = 1; v.jump = 1; v.jump_pc = 32'h50; tbl.push_back(v);
    v = r(32'h900, 1'b1, 1'b0); v.stall = 1; v.trap = 1; v.trap_vec = 32'hA00; tbl.push_back(v);
    v = r(32'hA00, 1'b1, 1'b0); v.jump = 1; v.jump_pc = 32'h3F;             tbl.push_back(v);
    v = r(32'h3C,  1'b1, 1'b0); v.jump = 1; v.call = 1; v.jump_pc = 32'h100; tbl.push_back(v);
    v = r(32'h100, 1'b1, 1'b0); v.stall = 1; v.ret = 1; v.ret_pc = 32'h0;   tbl.push_back(v);
    v = r(32'h100, 1'b1, 1'b1); v.ret = 1; v.ret_pc = 32'h0;                tbl.push_back(v);
    v = r(32'h40,  1'b1, 1'b0);                                             tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++) begin
      step_table(tbl[i], i);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      v = r(32'h0, 1'b0, 1'b0);
      v.start       = ($urandom_range(3) == 0);
      v.halt        = ($urandom_range(15) == 0);
      v.resume      = ($urandom_range(3) == 0);
      v.stall       = ($urandom_range(4) == 0);
      v.trap        = ($urandom_range(40) == 0);
      v.trap_vec    = $urandom;
      v.redirect    = ($urandom_range(9) == 0);
      v.redirect_pc = $urandom;
      v.jump        = ($urandom_range(3) == 0);
      v.jump_pc     = $urandom;
      v.call        = ($urandom_range(1) == 0);
      v.ret         = ($urandom_range(4) == 0);
      v.ret_pc      = $urandom;
      step_model(v, "rnd");
    end

    // Asynchronous reset in the middle of fetching at 0x40.
    v = r(32'h0, 1'b0, 1'b0); v.trap = 1; v.trap_vec = 32'h40;
    step_model(v, "to40");
    drive(r(32'h0, 1'b0, 1'b0));
    @(negedge clk_i);
    chk("pre_rst pc", bus.pc_o, 32'h40);
    chk("pre_rst valid", 32'(bus.valid_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst pc", bus.pc_o, 32'h0);
    chk("async_rst valid", 32'(bus.valid_o), 32'd0);
    #1 rst_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    v = r(32'h0, 1'b0, 1'b0); v.start = 1;
    drive(v);
    @(posedge clk_i);
    #1;
    drive(r(32'h0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk($sformatf("post_rst fetch%0d pc", i), bus.pc_o, 32'(i * 4));
      chk($sformatf("post_rst fetch%0d valid", i), 32'(bus.valid_o), 32'd1);
      @(posedge clk_i);
      #1;
    end

    // 16-bit instance: sequential step from the top of the space wraps to 0.
    chk("x16 reset pc", 32'(bus16.pc_o), 32'h0);
    bus16.start_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus16.start_i       = 1'b0;
    bus16.redirect_i    = 1'b1;
    bus16.redirect_pc_i = 16'hFFFC;
    @(posedge clk_i);
    #1;
    bus16.redirect_i = 1'b0;
    @(negedge clk_i);
    chk("x16 top pc", 32'(bus16.pc_o), 32'h0000_FFFC);
    chk("x16 top valid", 32'(bus16.valid_o), 32'd1);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("x16 wrap pc", 32'(bus16.pc_o), 32'h0);
    chk("x16 wrap valid", 32'(bus16.valid_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
